ieee754_divider_seq: RTL and testbench



---
 rtl/fp32_pkg.sv | 37 +++
 rtl/ieee754_divider_seq_if.sv | 27 ++
 rtl/fp_round_ne.sv | 39 +++
 rtl/ieee754_divider_seq.sv | 154 +++++++++++++++
 tb/tb_ieee754_divider_seq.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 field widths, divider state encoding, and the result payload.
package fp32_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = 24;
  localparam int unsigned QBITS   = 26;
  localparam int unsigned ETMP_W  = 10;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] mantissa;
    logic              div_by_zero;
    logic              overflow;
    logic              underflow;
  } div_res_t;

  function automatic fp32_t fp32_unpack(input logic [WORD_W-1:0] word);
    fp32_t f;
    f = word;
    return f;
  endfunction

endpackage

// File: rtl/ieee754_divider_seq_if.sv
// Operand and result handshake bundle for the sequential fp32 divider.
interface ieee754_divider_seq_if;
  import fp32_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] Number1;
  logic [WORD_W-1:0] Number2;
  logic              out_valid;
  logic              out_ready;
  logic              sign;
  logic [EXP_W-1:0]  Exponent;
  logic [FRAC_W-1:0] Mantissa;
  logic              div_by_zero;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  in_valid, Number1, Number2, out_ready,
    output in_ready, out_valid, sign, Exponent, Mantissa, div_by_zero, overflow, underflow
  );

  modport master (
    output in_valid, Number1, Number2, out_ready,
    input  in_ready, out_valid, sign, Exponent, Mantissa, div_by_zero, overflow, underflow
  );
endinterface

// File: rtl/fp_round_ne.sv
// Round-to-nearest-even of a normalised quotient plus exponent range clamp.
module fp_round_ne
  import fp32_pkg::*;
(
  input  logic [FRAC_W-1:0]        frac,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [ETMP_W-1:0] exp_in,
  output logic [FRAC_W-1:0]        frac_c,
  output logic [EXP_W-1:0]         exp_c,
  output logic                     overflow_c,
  output logic                     underflow_c
);

  localparam logic signed [ETMP_W-1:0] EMAX_S = ETMP_W'(EXP_MAX);
  localparam logic signed [ETMP_W-1:0] ZERO_S = '0;

  logic                     inc;
  logic [FRAC_W:0]          sum;
  logic signed [ETMP_W-1:0] exp_adj;

  // A carry out of the fraction leaves it zero and bumps the exponent.
  always_comb begin
    inc         = guard & (sticky | frac[0]);
    sum         = {1'b0, frac} + (FRAC_W+1)'(inc);
    exp_adj     = exp_in + ETMP_W'(sum[FRAC_W]);
    overflow_c  = (exp_adj >= EMAX_S);
    underflow_c = !overflow_c && (exp_adj <= ZERO_S);
    exp_c       = '0;
    frac_c      = '0;
    if (overflow_c) begin
      exp_c = '1;
    end else if (!underflow_c) begin
      exp_c  = exp_adj[EXP_W-1:0];
      frac_c = sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/ieee754_divider_seq.sv
// Sequential fp32 divider: restoring shift-subtract, one quotient bit per clock.
module ieee754_divider_seq
  import fp32_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  ieee754_divider_seq_if.slave bus
);

  state_t                   state, state_n;
  div_res_t                 res_q, res_n;
  logic                     in_ready_q, out_valid_q;
  logic [QBITS-1:0]         rem_q, q_q, sub_c;
  logic [MANT_W-1:0]        div_q;
  logic signed [ETMP_W-1:0] etmp_q, nexp_c;
  logic [CNT_W-1:0]         cnt_q;
  logic                     sign_q, ge_c;
  logic [FRAC_W-1:0]        nfrac_c, rnd_frac_c;
  logic                     nguard_c, nsticky_c;
  logic [EXP_W-1:0]         rnd_exp_c;
  logic                     rnd_ovf_c, rnd_unf_c;
  fp32_t                    op1_c, op2_c;

  assign op1_c = fp32_unpack(bus.Number1);
  assign op2_c = fp32_unpack(bus.Number2);

  assign ge_c  = (rem_q >= QBITS'(div_q));
  assign sub_c = ge_c ? (rem_q - QBITS'(div_q)) : rem_q;

  // Normalise: a leading 0 in q means the quotient was below 1.0.
  always_comb begin
    if (q_q[QBITS-1]) begin
      nfrac_c   = q_q[QBITS-2:2];
      nguard_c  = q_q[1];
      nsticky_c = q_q[0] | (rem_q != '0);
      nexp_c    = etmp_q;
    end else begin
      nfrac_c   = q_q[QBITS-3:1];
      nguard_c  = q_q[0];
      nsticky_c = (rem_q != '0);
      nexp_c    = etmp_q - ETMP_W'(1);
    end
  end

  fp_round_ne u_round (
    .frac        (nfrac_c),
    .guard       (nguard_c),
    .sticky      (nsticky_c),
    .exp_in      (nexp_c),
    .frac_c      (rnd_frac_c),
    .exp_c       (rnd_exp_c),
    .overflow_c  (rnd_ovf_c),
    .underflow_c (rnd_unf_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Result payload is only re-evaluated on the way into DONE.
  always_comb begin
    state_n = state;
    res_n   = res_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (op2_c.exp == '0) begin
            res_n             = '0;
            res_n.sign        = op1_c.sign ^ op2_c.sign;
            res_n.exponent    = '1;
            res_n.div_by_zero = 1'b1;
            state_n           = DONE;
          end else if (op1_c.exp == '0) begin
            res_n      = '0;
            res_n.sign = op1_c.sign ^ op2_c.sign;
            state_n    = DONE;
          end else begin
            state_n = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(QBITS-1)) state_n = ROUND;
      end
      ROUND: begin
        res_n           = '0;
        res_n.sign      = sign_q;
        res_n.exponent  = rnd_exp_c;
        res_n.mantissa  = rnd_frac_c;
        res_n.overflow  = rnd_ovf_c;
        res_n.underflow = rnd_unf_c;
        state_n         = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_n;
      in_ready_q  <= (state_n == IDLE);
      out_valid_q <= (state_n == DONE);
    end
  end

  // Shift-subtract datapath; operands are latched on the accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      div_q  <= '0;
      q_q    <= '0;
      etmp_q <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q <= op1_c.sign ^ op2_c.sign;
            rem_q  <= QBITS'({1'b1, op1_c.frac});
            div_q  <= {1'b1, op2_c.frac};
            etmp_q <= ETMP_W'(op1_c.exp) - ETMP_W'(op2_c.exp) + ETMP_W'(BIAS);
            q_q    <= '0;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          rem_q <= {sub_c[QBITS-2:0], 1'b0};
          q_q   <= {q_q[QBITS-2:0], ge_c};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.sign        = res_q.sign;
  assign bus.Exponent    = res_q.exponent;
  assign bus.Mantissa    = res_q.mantissa;
  assign bus.div_by_zero = res_q.div_by_zero;
  assign bus.overflow    = res_q.overflow;
  assign bus.underflow   = res_q.underflow;

endmodule

// File: tb/tb_ieee754_divider_seq.sv
// Directed scoreboard bench for the sequential fp32 divider.
module tb_ieee754_divider_seq;
  import fp32_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   lat;
  int   seen;
  div_res_t sb[$];
  div_res_t hold_exp;

  ieee754_divider_seq_if bus();

  ieee754_divider_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic div_res_t mk(input logic s, input logic [7:0] e, input logic [22:0] m,
                                  input logic dz, input logic ov, input logic un);
    div_res_t r;
    r.sign = s; r.exponent = e; r.mantissa = m;
    r.div_by_zero = dz; r.overflow = ov; r.underflow = un;
    return r;
  endfunction

  function automatic div_res_t obs();
    div_res_t r;
    r.sign = bus.sign; r.exponent = bus.Exponent; r.mantissa = bus.Mantissa;
    r.div_by_zero = bus.div_by_zero; r.overflow = bus.overflow; r.underflow = bus.underflow;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input string tag, input logic [31:0] n1, input logic [31:0] n2,
                      input div_res_t e);
    bus.Number1  = n1;
    bus.Number2  = n2;
    bus.in_valid = 1'b1;
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Index 0 is the sample just after the accept edge; bounded wait.
  task automatic wait_valid(input string tag, output int l);
    l = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) begin
        l = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic release_result(input string tag);
    div_res_t e;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, " result"}, 64'(obs()), 64'(e));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " cleared"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] n1, input logic [31:0] n2,
                        input div_res_t e, input int exp_lat);
    int l;
    send(tag, n1, n2, e);
    wait_valid(tag, l);
    if (exp_lat >= 0) check({tag, " latency"}, 64'(l), 64'(exp_lat));
    else              check({tag, " latency<=1"}, 64'(l >= 0 && l <= 1), 64'd1);
    release_result(tag);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.Number1 = '0;
    bus.Number2 = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset outputs", 64'(obs()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("6/2",    32'h40C00000, 32'h40000000, mk(1'b0, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0), 27);
    run_op("1/3",    32'h3F800000, 32'h40400000, mk(1'b0, 8'h7D, 23'h2AAAAB, 1'b0, 1'b0, 1'b0), 27);
    run_op("-1/2",   32'hBF800000, 32'h40000000, mk(1'b1, 8'h7E, 23'h000000, 1'b0, 1'b0, 1'b0), 27);
    run_op("2/3",    32'h40000000, 32'h40400000, mk(1'b0, 8'h7E, 23'h2AAAAB, 1'b0, 1'b0, 1'b0), 27);
    run_op("-1/-3",  32'hBF800000, 32'hC0400000, mk(1'b0, 8'h7D, 23'h2AAAAB, 1'b0, 1'b0, 1'b0), 27);
    run_op("10/5",   32'h41200000, 32'h40A00000, mk(1'b0, 8'h80, 23'h000000, 1'b0, 1'b0, 1'b0), 27);
    run_op("1/0",    32'h3F800000, 32'h00000000, mk(1'b0, 8'hFF, 23'h000000, 1'b1, 1'b0, 1'b0), -1);
    run_op("-0/2",   32'h80000000, 32'h40000000, mk(1'b1, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b0), -1);
    run_op("ovf",    32'h7F000000, 32'h00800000, mk(1'b0, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b0), 27);
    run_op("unf",    32'h00800000, 32'h7F000000, mk(1'b0, 8'h00, 23'h000000, 1'b0, 1'b0, 1'b1), 27);

    // Backpressure: result held, new operands offered but not taken.
    send("bp", 32'h40C00000, 32'h40000000, mk(1'b0, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0));
    hold_exp = sb[0];
    wait_valid("bp", lat);
    for (int i = 0; i < 10; i++) begin
      bus.Number1  = 32'h3F800000;
      bus.Number2  = 32'h40400000;
      bus.in_valid = 1'b1;
      check("bp hold valid", 64'(bus.out_valid), 64'd1);
      check("bp hold in_ready", 64'(bus.in_ready), 64'd0);
      check("bp hold result", 64'(obs()), 64'(hold_exp));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    release_result("bp");
    check("bp in_ready after release", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    check("bp single accept", 64'(seen), 64'd0);

    // Reset in the middle of CALC aborts the operation.
    send("rst", 32'h40C00000, 32'h40000000, mk(1'b0, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0));
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst outputs", 64'(obs()), 64'd0);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    check("rst no partial result", 64'(seen), 64'd0);
    run_op("6/2 after rst", 32'h40C00000, 32'h40000000,
           mk(1'b0, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0), 27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
